pcm_channel_mixer: RTL and testbench
====================================

Name: pcm_channel_mixer

Overview:
Mixes the bytebeat generator PCM streams into one 8-bit sample for a single shared PWM output. Sits between the generator bank and the PWM audio stage. Holds the latest valid sample of each channel and runs a sequential accumulate pass per output sample tick. Applies per-channel enable masking and master volume, then presents the result on a valid/ready handshake.

Parameters:
CHANNELS, 8, number of PCM input channels; must be a power of 2, range 2..16.
MIX_MODE, 0, 0 = average (sum >> log2(CHANNELS)); 1 = saturating sum clamped to 255.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
sample_tick  in  1  one-cycle pulse; requests a new mixed sample
pcm_in  in  8*CHANNELS  packed channel samples; channel i occupies bits [8i+7:8i]
pcm_vld  in  CHANNELS  per-channel valid; the sample is captured when high
ch_enable  in  CHANNELS  per-channel mix enable; a disabled channel contributes 0
volume  in  4  master volume; 15 = unity, 0 = 1/16
mix_out  out  8  mixed sample, held stable while mix_vld is high
mix_vld  out  1  mixed sample valid
mix_rdy  in  1  consumer ready
busy  out  1  high in any state other than IDLE
overrun  out  8  saturating count of dropped ticks

Behaviour:
- Reset (async, rst_n=0): all hold registers = 0x00, acc = 0, idx = 0, state = IDLE, mix_out = 0x00, mix_vld = 0, overrun = 0, busy = 0.
- Capture: on every edge in every state, hold[i] <= pcm_in[i] when pcm_vld[i]=1. Otherwise hold[i] keeps its value.
- FSM states: IDLE, ACCUM, SCALE, OUT.
- IDLE: if sample_tick=1, go to ACCUM with acc <= 0 and idx <= 0, and latch ch_enable and volume into snapshot registers.
- ACCUM: each cycle, acc <= acc + (en_snap[idx] ? hold[idx] : 0) and idx <= idx+1. The hold value is read live, so a capture on the same edge is not seen. After idx = CHANNELS-1, go to SCALE.
- acc width: 8 + log2(CHANNELS) bits; it cannot overflow.
- SCALE: compute mix as follows.
  - MIX_MODE=0: mix = acc >> log2(CHANNELS).
  - MIX_MODE=1: mix = (acc > 255) ? 255 : acc.
  - Then mix_out <= (mix * (vol_snap+1)) >> 4. The product is 13 bits; take bits [11:4]. Go to OUT.
- OUT: mix_vld = 1. mix_out is stable until the transfer. On an edge with mix_rdy=1, go to IDLE and mix_vld falls.
- mix_vld is registered and derived only from state; no combinational path from mix_rdy.
- mix_out retains its last value in IDLE/ACCUM/SCALE.
- Latency: tick sampled at edge E0 → accumulation on E1..E_CHANNELS → mix_vld high after edge E(CHANNELS+1). For CHANNELS=8 that is 9 cycles.
- Overrun: sample_tick=1 in ACCUM, SCALE or OUT, including the OUT cycle where mix_rdy=1, drops the tick. overrun increments, saturating at 255.
- A tick is accepted only in IDLE. There is no queueing.
- Snapshot: ch_enable and volume changes during a pass do not affect that pass.
- Reset mid-pass: immediate return to IDLE with all outputs at their reset values. The partial acc is discarded.

Decomposition:
- Package pcm_mixer_pkg contains:
  - state enum (IDLE, ACCUM, SCALE, OUT);
  - PCM_W = 8 and VOL_W = 4;
  - function clog2 for acc and idx widths.
- One combinational sub-module, pcm_volume_scale (8-bit sample × 4-bit volume → 8-bit output), so it can be reused by the PWM path and tested standalone.
- The FSM, hold registers and accumulator stay in pcm_channel_mixer.

Test Plan:
1. All 8 channels at 0x80 (vld pulsed), all enabled, MIX_MODE=0, volume=15, tick, mix_rdy=1 → mix_out=0x80, mix_vld rises 9 cycles after the tick and is high for 1 cycle.
2. Channel 3 = 0xFF only enabled, others 0x00, MIX_MODE=0, volume=15 → mix_out=0x1F.
3. MIX_MODE=1, channels 0 and 1 = 0xC0 enabled, rest disabled → mix_out=0xFF (saturated). With channel 0 = 0x10 and channel 1 = 0x20 → 0x30.
4. Mix 0x80 with volume=7 → mix_out=0x40; volume=0 → 0x08.
5. Backpressure: mix_rdy=0 for 5 cycles in OUT with 2 ticks issued → mix_out held and mix_vld held high; overrun=2; release rdy → IDLE. Next tick is accepted normally.
6. rst_n asserted during cycle 4 of ACCUM → outputs are 0 immediately (async). After release, a tick gives a clean result identical to scenario 1; overrun=0.

Source files
------------

// File: rtl/pcm_mixer_pkg.sv
// Shared types and constants for the PCM channel mixer and its volume stage.
package pcm_mixer_pkg;

    localparam int PCM_W = 8;
    localparam int VOL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCALE = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Ceiling log2, usable in localparam expressions for acc/idx widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pcm_volume_scale.sv
// Master volume stage: out = (sample * (volume + 1)) >> 4, so 15 is unity gain.
module pcm_volume_scale
    import pcm_mixer_pkg::*;
(
    input  logic [PCM_W-1:0] sample_i,
    input  logic [VOL_W-1:0] volume_i,
    output logic [PCM_W-1:0] sample_o
);

    logic [VOL_W:0]   vol_p1_s;
    logic [11:0]      prod_s;

    // The product never exceeds 255 * 16, so 12 bits hold it exactly.
    always_comb begin
        vol_p1_s = {1'b0, volume_i} + 5'd1;
        prod_s   = 12'(sample_i) * 12'(vol_p1_s);
        sample_o = PCM_W'(prod_s >> 4);
    end

endmodule

// File: rtl/pcm_channel_mixer.sv
// Mixes CHANNELS held PCM samples into one 8-bit sample per tick, with enable
// masking, master volume and a valid/ready output handshake.
module pcm_channel_mixer
    import pcm_mixer_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int MIX_MODE = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      sample_tick_i,
    input  logic [PCM_W*CHANNELS-1:0] pcm_in_i,
    input  logic [CHANNELS-1:0]       pcm_vld_i,
    input  logic [CHANNELS-1:0]       ch_enable_i,
    input  logic [VOL_W-1:0]          volume_i,
    output logic [PCM_W-1:0]          mix_out_o,
    output logic                      mix_vld_o,
    input  logic                      mix_rdy_i,
    output logic                      busy_o,
    output logic [7:0]                overrun_o
);

    localparam int IDX_W = clog2(CHANNELS);
    localparam int ACC_W = PCM_W + IDX_W;

    logic [PCM_W-1:0]    hold_q [CHANNELS];
    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CHANNELS-1:0] en_snap_q, en_snap_d;
    logic [VOL_W-1:0]    vol_snap_q, vol_snap_d;
    logic [PCM_W-1:0]    mix_out_q, mix_out_d;
    logic                mix_vld_q, mix_vld_d;
    logic                busy_q, busy_d;
    logic [7:0]          overrun_q, overrun_d;

    logic [ACC_W-1:0]    addend_s;
    logic [PCM_W-1:0]    mix_s;
    logic [PCM_W-1:0]    scaled_s;

    // Per-channel sample capture, independent of the mixing FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < CHANNELS; i++) begin
                hold_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (pcm_vld_i[i]) begin
                    hold_q[i] <= pcm_in_i[PCM_W*i +: PCM_W];
                end else begin
                    hold_q[i] <= hold_q[i];
                end
            end
        end
    end

    // Contribution of the channel currently addressed by the accumulate pass.
    always_comb begin
        if (en_snap_q[idx_q]) begin
            addend_s = ACC_W'(hold_q[idx_q]);
        end else begin
            addend_s = {ACC_W{1'b0}};
        end
    end

    // Reduce the accumulator to 8 bits: average or saturating sum.
    always_comb begin
        if (MIX_MODE == 0) begin
            mix_s = PCM_W'(acc_q >> IDX_W);
        end else if (acc_q > ACC_W'(255)) begin
            mix_s = 8'hFF;
        end else begin
            mix_s = acc_q[PCM_W-1:0];
        end
    end

    pcm_volume_scale u_volume_scale (
        .sample_i (mix_s),
        .volume_i (vol_snap_q),
        .sample_o (scaled_s)
    );

    // FSM next state, accumulator, snapshots, output and overrun counter.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        en_snap_d  = en_snap_q;
        vol_snap_d = vol_snap_q;
        mix_out_d  = mix_out_q;
        mix_vld_d  = mix_vld_q;
        overrun_d  = overrun_q;

        // Ticks are only accepted in IDLE; anywhere else they are dropped.
        if (sample_tick_i && (state_q != ST_IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_tick_i) begin
                    state_d    = ST_ACCUM;
                    acc_d      = {ACC_W{1'b0}};
                    idx_d      = {IDX_W{1'b0}};
                    en_snap_d  = ch_enable_i;
                    vol_snap_d = volume_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + addend_s;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(CHANNELS - 1)) begin
                    state_d = ST_SCALE;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_SCALE: begin
                mix_out_d = scaled_s;
                mix_vld_d = 1'b1;
                state_d   = ST_OUT;
            end
            ST_OUT: begin
                if (mix_rdy_i) begin
                    mix_vld_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d   = ST_OUT;
                end
            end
            default: begin
                mix_vld_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            acc_q      <= {ACC_W{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            en_snap_q  <= {CHANNELS{1'b0}};
            vol_snap_q <= 4'd0;
            mix_out_q  <= 8'h00;
            mix_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            en_snap_q  <= en_snap_d;
            vol_snap_q <= vol_snap_d;
            mix_out_q  <= mix_out_d;
            mix_vld_q  <= mix_vld_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign mix_out_o = mix_out_q;
    assign mix_vld_o = mix_vld_q;
    assign busy_o    = busy_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_pcm_channel_mixer.sv
// Self-checking bench: an averaging and a saturating mixer share all stimulus
// and are compared against hand vectors and an arithmetic reference model.
module tb_pcm_channel_mixer;

    localparam int CH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_tick;
    logic [63:0]   pcm_in;
    logic [7:0]    pcm_vld;
    logic [7:0]    ch_enable;
    logic [3:0]    volume;
    logic          mix_rdy;
    logic [7:0]    mix_out0, mix_out1;
    logic          mix_vld0, mix_vld1;
    logic          busy0, busy1;
    logic [7:0]    ovr0, ovr1;

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [7:0]    mdl_hold [CH];
    int            mdl_ovr;

    typedef struct {
        logic [63:0] pcm;
        logic [7:0]  en;
        logic [3:0]  vol;
        logic [7:0]  exp0;
        logic [7:0]  exp1;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    pcm_channel_mixer #(.CHANNELS(CH), .MIX_MODE(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .sample_tick_i(sample_tick),
        .pcm_in_i(pcm_in), .pcm_vld_i(pcm_vld), .ch_enable_i(ch_enable),
        .volume_i(volume), .mix_out_o(mix_out0), .mix_vld_o(mix_vld0),
        .mix_rdy_i(mix_rdy), .busy_o(busy0), .overrun_o(ovr0)
    );

    pcm_channel_mixer #(.CHANNELS(CH), .MIX_MODE(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .sample_tick_i(sample_tick),
        .pcm_in_i(pcm_in), .pcm_vld_i(pcm_vld), .ch_enable_i(ch_enable),
        .volume_i(volume), .mix_out_o(mix_out1), .mix_vld_o(mix_vld1),
        .mix_rdy_i(mix_rdy), .busy_o(busy1), .overrun_o(ovr1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_mix(input int mode, input logic [7:0] en, input logic [3:0] vol);
        int sum;
        int mix;
        sum = 0;
        for (int i = 0; i < CH; i++) begin
            if (en[i]) sum += int'(mdl_hold[i]);
        end
        if (mode == 0) mix = sum / CH;
        else           mix = (sum > 255) ? 255 : sum;
        return 8'((mix * (int'(vol) + 1)) / 16);
    endfunction

    task automatic load(input logic [63:0] v, input logic [7:0] m);
        pcm_in  = v;
        pcm_vld = m;
        @(posedge clk); #1;
        pcm_vld = 8'h00;
        for (int i = 0; i < CH; i++) begin
            if (m[i]) mdl_hold[i] = v[8*i +: 8];
        end
    endtask

    // One edge while the mixer is busy; any tick driven for it is a drop.
    task automatic busy_edge(input int policy, input bit forced);
        sample_tick = forced || (policy == 2) || (policy == 1 && $urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        if (sample_tick && mdl_ovr < 255) mdl_ovr++;
        sample_tick = 1'b0;
    endtask

    task automatic do_pass(input logic [7:0] en, input logic [3:0] vol,
                           input logic [7:0] exp0, input logic [7:0] exp1,
                           input int stall, input int policy, input logic [7:0] stall_mask);
        int cyc;
        logic [7:0] held0, held1;
        sample_tick = 1'b1;
        ch_enable   = en;
        volume      = vol;
        mix_rdy     = 1'b0;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        ch_enable   = ~en;
        volume      = ~vol;
        cyc = 0;
        while (mix_vld0 !== 1'b1 && cyc < 20) begin
            busy_edge(policy, 1'b0);
            cyc++;
            if (cyc == 1) chk("busy_in_pass", busy0, 1'b1);
        end
        chk("latency", cyc, 9);
        chk("vld_mode1", mix_vld1, 1'b1);
        chk("mix_avg", mix_out0, exp0);
        chk("mix_sat", mix_out1, exp1);
        held0 = mix_out0;
        held1 = mix_out1;
        for (int s = 0; s < stall; s++) begin
            busy_edge(policy, (s < 8) ? stall_mask[s] : 1'b0);
            chk("vld_held", mix_vld0, 1'b1);
            chk("out_held_avg", mix_out0, held0);
            chk("out_held_sat", mix_out1, held1);
        end
        mix_rdy = 1'b1;
        busy_edge(policy, 1'b0);
        mix_rdy = 1'b0;
        chk("vld_fall_avg", mix_vld0, 1'b0);
        chk("vld_fall_sat", mix_vld1, 1'b0);
        chk("busy_idle", busy0, 1'b0);
        chk("overrun_avg", ovr0, mdl_ovr);
        chk("overrun_sat", ovr1, mdl_ovr);
    endtask

    initial begin
        tbl[0] = '{64'h8080808080808080, 8'hFF, 4'd15, 8'h80, 8'hFF};
        tbl[1] = '{64'h00000000FF000000, 8'h08, 4'd15, 8'h1F, 8'hFF};
        tbl[2] = '{64'h000000000000C0C0, 8'h03, 4'd15, 8'h30, 8'hFF};
        tbl[3] = '{64'h0000000000002010, 8'h03, 4'd15, 8'h06, 8'h30};
        tbl[4] = '{64'h8080808080808080, 8'hFF, 4'd7,  8'h40, 8'h7F};
        tbl[5] = '{64'h8080808080808080, 8'hFF, 4'd0,  8'h08, 8'h0F};

        rst_n = 1'b0; sample_tick = 1'b0; pcm_in = 64'd0; pcm_vld = 8'h00;
        ch_enable = 8'h00; volume = 4'd0; mix_rdy = 1'b0;
        mdl_ovr = 0;
        for (int i = 0; i < CH; i++) mdl_hold[i] = 8'h00;

        #12;
        chk("rst_out", mix_out0, 8'h00);
        chk("rst_vld", mix_vld0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_ovr", ovr0, 8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            load(tbl[i].pcm, 8'hFF);
            do_pass(tbl[i].en, tbl[i].vol, tbl[i].exp0, tbl[i].exp1, 0, 0, 8'h00);
        end

        // Backpressure: five stalled OUT cycles with two dropped ticks.
        load(64'h8080808080808080, 8'hFF);
        do_pass(8'hFF, 4'd15, 8'h80, 8'hFF, 5, 0, 8'b0000_1010);
        chk("bp_overrun", ovr0, 8'd2);
        do_pass(8'hFF, 4'd15, 8'h80, 8'hFF, 0, 0, 8'h00);
        chk("bp_next_overrun", ovr0, 8'd2);

        // Asynchronous reset in the middle of the accumulate pass.
        sample_tick = 1'b1; ch_enable = 8'hFF; volume = 4'd15;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out", mix_out0, 8'h00);
        chk("midrst_vld", mix_vld0, 1'b0);
        chk("midrst_busy", busy0, 1'b0);
        chk("midrst_ovr", ovr0, 8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mdl_ovr = 0;
        for (int i = 0; i < CH; i++) mdl_hold[i] = 8'h00;
        load(64'h8080808080808080, 8'hFF);
        do_pass(8'hFF, 4'd15, 8'h80, 8'hFF, 0, 0, 8'h00);
        chk("post_rst_ovr", ovr0, 8'd0);

        // Randomised passes against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] en_r;
            logic [3:0] vol_r;
            load({$urandom, $urandom}, 8'($urandom));
            en_r  = 8'($urandom);
            vol_r = 4'($urandom);
            do_pass(en_r, vol_r, model_mix(0, en_r, vol_r), model_mix(1, en_r, vol_r),
                    $urandom_range(0, 3), 1, 8'h00);
        end

        // Overrun counter saturation under continuous ticks while stalled.
        load(64'h0102030405060708, 8'hFF);
        do_pass(8'hFF, 4'd15, model_mix(0, 8'hFF, 4'd15), model_mix(1, 8'hFF, 4'd15),
                270, 2, 8'h00);
        chk("ovr_saturated", ovr0, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
